// File: rtl/pm_pkg.sv
// Shared PPE-side packet definitions: field positions, opcodes, weight geometry
// and the weight-loader state encoding.
package pm_pkg;

   localparam int PKT_W     = 33;
   localparam int ADDR_MSB  = 32;
   localparam int ADDR_LSB  = 29;
   localparam int OP_MSB    = 28;
   localparam int OP_LSB    = 25;
   localparam int DATA_MSB  = 24;
   localparam int DATA_LSB  = 0;

   localparam logic [3:0] OP_WEIGHT  = 4'd0;
   localparam logic [3:0] OP_TS_DONE = 4'd15;

   localparam int WEIGHT_WIDTH = 8;
   localparam int NUM_W        = 5;
   localparam int ROW_W        = WEIGHT_WIDTH * NUM_W;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_SECOND = 2'd1,
      S_FULL   = 2'd2
   } wl_state_t;

   // Assemble a packet from its fields; used by the memory/router side.
   function automatic pkt_t make_pkt(input logic [3:0] addr, input logic [3:0] op,
                                     input logic [DATA_MSB:DATA_LSB] data);
      return {addr, op, data};
   endfunction

endpackage

// File: rtl/pkt_decode.sv
// Combinational router-packet field split and classification for a PPE receiver.
module pkt_decode
   import pm_pkg::*;
#(
   parameter logic [3:0] PE_ID = 4'd5
) (
   input  pkt_t                        pkt_i,
   output logic [DATA_MSB:DATA_LSB]    data_o,
   output logic                        addr_match_o,
   output logic                        is_weight_o,
   output logic                        is_ts_o,
   output logic                        is_bad_op_o
);

   logic [3:0] addr;
   logic [3:0] opcode;

   // Field split and opcode classification; address check is independent of opcode.
   always_comb begin
      addr         = pkt_i[ADDR_MSB:ADDR_LSB];
      opcode       = pkt_i[OP_MSB:OP_LSB];
      data_o       = pkt_i[DATA_MSB:DATA_LSB];
      addr_match_o = (addr == PE_ID);
      is_weight_o  = (opcode == OP_WEIGHT);
      is_ts_o      = (opcode == OP_TS_DONE);
      is_bad_op_o  = !is_weight_o && !is_ts_o;
   end

endmodule

// File: rtl/ppe_weight_loader.sv
// PPE weight ingest: assembles two router packets into one 5-weight row and
// holds it for the MAC datapath until released.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FIRST  | waiting for packet carrying weights 0-2
// S_SECOND | weights 0-2 buffered, waiting for packet carrying weights 3-4
// S_FULL   | complete row presented on w_row, waiting for w_ack
module ppe_weight_loader
   import pm_pkg::*;
#(
   parameter logic [3:0] PE_ID = 4'd5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pkt_valid,
   output logic               pkt_ready,
   input  logic [PKT_W-1:0]   pkt_data,
   output logic [ROW_W-1:0]   w_row,
   output logic               w_valid,
   input  logic               w_ack,
   output logic               ts_done,
   output logic               err_addr,
   output logic               err_op,
   output logic [7:0]         row_count
);

   wl_state_t                 state_q, state_d;
   logic [3*WEIGHT_WIDTH-1:0] lo_q, lo_d;
   logic [ROW_W-1:0]          row_q, row_d;
   logic                      ts_q, ts_d;
   logic                      err_addr_q, err_addr_d;
   logic                      err_op_q, err_op_d;
   logic [7:0]                cnt_q, cnt_d;

   logic [DATA_MSB:DATA_LSB]  dec_data;
   logic                      dec_addr_match;
   logic                      dec_is_weight;
   logic                      dec_is_ts;
   logic                      dec_is_bad_op;
   logic                      accept;
   logic                      unused_data_b24;

   pkt_decode #(.PE_ID(PE_ID)) u_dec (
      .pkt_i        (pkt_data),
      .data_o       (dec_data),
      .addr_match_o (dec_addr_match),
      .is_weight_o  (dec_is_weight),
      .is_ts_o      (dec_is_ts),
      .is_bad_op_o  (dec_is_bad_op)
   );

   // Data bit 24 carries nothing for weight or timestep packets.
   assign unused_data_b24 = dec_data[24];

   // Ready and row-valid are pure decodes of the state register.
   assign pkt_ready = (state_q != S_FULL);
   assign w_valid   = (state_q == S_FULL);
   assign accept    = pkt_valid && pkt_ready;

   assign w_row     = row_q;
   assign ts_done   = ts_q;
   assign err_addr  = err_addr_q;
   assign err_op    = err_op_q;
   assign row_count = cnt_q;

   // Next-state: packet classification, row assembly and release on ack.
   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      row_d      = row_q;
      ts_d       = 1'b0;
      err_addr_d = err_addr_q;
      err_op_d   = err_op_q;
      cnt_d      = cnt_q;

      if (accept) begin
         if (!dec_addr_match) begin
            err_addr_d = 1'b1;
         end else if (dec_is_weight) begin
            if (state_q == S_FIRST) begin
               lo_d    = dec_data[23:0];
               state_d = S_SECOND;
            end else begin
               // Whole row lands at once so w_row never shows a half-updated row.
               row_d   = {dec_data[15:0], lo_q};
               cnt_d   = cnt_q + 8'd1;
               state_d = S_FULL;
            end
         end else if (dec_is_ts) begin
            ts_d = 1'b1;
         end else if (dec_is_bad_op) begin
            err_op_d = 1'b1;
         end
      end

      if (state_q == S_FULL && w_ack) begin
         state_d = S_FIRST;
      end
   end

   // State and datapath registers; reset discards any partially loaded row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FIRST;
         lo_q       <= '0;
         row_q      <= '0;
         ts_q       <= 1'b0;
         err_addr_q <= 1'b0;
         err_op_q   <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         row_q      <= row_d;
         ts_q       <= ts_d;
         err_addr_q <= err_addr_d;
         err_op_q   <= err_op_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule
